bpf_code_loader: RTL and testbench
==================================

Name: bpf_code_loader

Overview:
Sequencer between the host command path and the packet filter's instruction memory and control_start input. Accepts a BPF program as a stream of 64-bit instruction words. Stops the filter cores and waits for them to go idle. Writes the words into instruction memory at consecutive addresses, then re-asserts control_start. This replaces the forced inst_wr_* / control_start hookup with a safe hot-reload path.

Parameters:
INST_MEM_DEPTH, 512, depth of the filter instruction memory in words; power of two, 2..65536.
CODE_DATA_WIDTH, 64, instruction word width.
CODE_ADDR_WIDTH, clog2(INST_MEM_DEPTH), instruction address width (derived).

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
cmd_TDATA  in  CODE_DATA_WIDTH  instruction word.
cmd_TVALID  in  1  word valid.
cmd_TLAST  in  1  final word of the program.
cmd_TREADY  out  1  word accepted when TVALID&&TREADY.
filt_idle  in  1  high when no filter core is executing or holding a packet.
control_start  out  1  enables the filter cores.
inst_wr_addr  out  CODE_ADDR_WIDTH  instruction memory write address.
inst_wr_data  out  CODE_DATA_WIDTH  instruction memory write data.
inst_wr_en  out  1  instruction memory write strobe.
prog_len  out  CODE_ADDR_WIDTH+1  number of words written by the last completed load.
load_done  out  1  single-cycle pulse when a load completes.
err_overflow  out  1  sticky: the last load supplied more than INST_MEM_DEPTH words.

Behaviour:
- Reset (sync, all outputs registered):
  - State IDLE.
  - control_start=0, cmd_TREADY=0, inst_wr_en=0, inst_wr_addr=0, inst_wr_data=0.
  - prog_len=0, load_done=0, err_overflow=0.
  - rst mid-load aborts the load; the partial program is left in memory and the filter stays stopped.
- States:
  - IDLE: control_start=0. cmd_TVALID=1 -> DRAIN.
  - RUN: control_start=1. cmd_TVALID=1 -> DRAIN; control_start drops on the registered transition.
  - DRAIN: control_start=0, cmd_TREADY=0. filt_idle=1 sampled -> LOAD. No timeout; waits indefinitely.
  - LOAD: cmd_TREADY=1. Accepted beat with TLAST=1 -> COMMIT.
  - COMMIT: one cycle; cmd_TREADY=0; the final write is on inst_wr_en this cycle. Next state RUN, with control_start=1 from the following cycle.
- On entry to LOAD:
  - Word counter cleared to 0.
  - err_overflow cleared.
  - Address counter cleared to 0.
- Write path, latency 1:
  - Beat accepted in cycle t -> inst_wr_en=1 in cycle t+1, with inst_wr_addr=counter and inst_wr_data=TDATA.
  - Counter increments per accepted beat.
  - inst_wr_en=0 on cycles with no accepted beat; TVALID gaps are allowed.
- Overflow: beats with counter >= INST_MEM_DEPTH are:
  - accepted (TREADY stays 1, to drain the stream to TLAST);
  - not written (inst_wr_en=0);
  - flagged by setting err_overflow=1.
  - The address never wraps.
- Counter width is CODE_ADDR_WIDTH+1 and saturates at INST_MEM_DEPTH.
- prog_len updates in COMMIT to min(beats accepted, INST_MEM_DEPTH).
- load_done pulses in the cycle RUN is entered.
- Single-word program (first beat has TLAST=1): prog_len=1, address 0 written.
- cmd_TVALID held during RUN / IDLE is not consumed until LOAD; the first word is never lost.
- filt_idle already high on entry to DRAIN: DRAIN lasts exactly 1 cycle.
- control_start=0 continuously from DRAIN entry through COMMIT, inclusive.

Test Plan:
- Reset then 4-word program (0x11..0x44, TLAST on 4th), filt_idle=1:
  - writes addr 0..3 with data 0x11..0x44 at 1-cycle latency;
  - COMMIT, then control_start=1;
  - prog_len=4, load_done one pulse, err_overflow=0.
- In RUN, new 2-word program with filt_idle=0 for 10 cycles:
  - control_start falls one cycle after TVALID;
  - cmd_TREADY=0 and no inst_wr_en for 10 cycles;
  - then addr 0,1 written, prog_len=2.
- 6-word program with TVALID deasserted 3 cycles between beats 2 and 3: exactly 6 inst_wr_en pulses, addresses 0..5 contiguous.
- 514-word program into depth 512:
  - all 514 beats accepted;
  - 512 writes (addr 0..511), no write to addr 0 after the first;
  - err_overflow=1, prog_len=512.
- Then a 1-word program (TLAST on first beat): err_overflow clears at LOAD entry, addr 0 written, prog_len=1.
- rst asserted during LOAD after 3 beats:
  - next cycle all outputs at reset values and state IDLE;
  - control_start stays 0 until a new load completes.

Source files
------------

// File: rtl/bpf_code_loader.sv
// bpf_code_loader
// Hot-reload sequencer for the packet filter instruction memory. A new
// program arriving on the cmd stream stops the filter cores, waits for them
// to drain, and writes the program to consecutive instruction addresses. The
// cores are then restarted. All outputs come straight from flops.
`timescale 1ns/1ps

module bpf_code_loader #(
    parameter  int INST_MEM_DEPTH  = 512,
    parameter  int CODE_DATA_WIDTH = 64,
    localparam int CODE_ADDR_WIDTH = $clog2(INST_MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CODE_DATA_WIDTH-1:0] cmd_TDATA,
    input  logic                       cmd_TVALID,
    input  logic                       cmd_TLAST,
    output logic                       cmd_TREADY,
    input  logic                       filt_idle,
    output logic                       control_start,
    output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [CODE_DATA_WIDTH-1:0] inst_wr_data,
    output logic                       inst_wr_en,
    output logic [CODE_ADDR_WIDTH:0]   prog_len,
    output logic                       load_done,
    output logic                       err_overflow
);

    // Word count at which the instruction memory is full, in counter width.
    localparam logic [CODE_ADDR_WIDTH:0] DEPTH_CNT = INST_MEM_DEPTH[CODE_ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        ST_IDLE,    // never loaded (or reset): filter stopped
        ST_RUN,     // program loaded, filter enabled
        ST_DRAIN,   // filter stopped, waiting for cores to go idle
        ST_LOAD,    // accepting program words
        ST_COMMIT   // last write in flight, restart next cycle
    } state_e;

    state_e                       state_q,         state_d;
    logic                         control_start_q, control_start_d;
    logic                         cmd_tready_q,    cmd_tready_d;
    logic                         wr_en_q,         wr_en_d;
    logic [CODE_ADDR_WIDTH-1:0]   wr_addr_q,       wr_addr_d;
    logic [CODE_DATA_WIDTH-1:0]   wr_data_q,       wr_data_d;
    logic [CODE_ADDR_WIDTH:0]     word_cnt_q,      word_cnt_d;
    logic [CODE_ADDR_WIDTH:0]     prog_len_q,      prog_len_d;
    logic                         load_done_q,     load_done_d;
    logic                         err_overflow_q,  err_overflow_d;

    logic                         beat_accepted;
    logic                         mem_full;

    // A beat is taken only while the registered ready is high, so the
    // handshake seen by the host matches what the loader acts on.
    assign beat_accepted = cmd_TVALID && cmd_tready_q;

    // The word counter stops at the memory depth, so this also marks overflow beats.
    assign mem_full = (word_cnt_q >= DEPTH_CNT);

    // Next-state and next-output logic for the reload sequence.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can leave one unassigned and infer a latch.
        state_d         = state_q;
        control_start_d = control_start_q;
        cmd_tready_d    = 1'b0;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        word_cnt_d      = word_cnt_q;
        prog_len_d      = prog_len_q;
        load_done_d     = 1'b0;
        err_overflow_d  = err_overflow_q;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                // A pending word is only noticed here; it is not consumed
                // until ready is raised in LOAD, so it cannot be lost.
                if (cmd_TVALID) begin
                    state_d         = ST_DRAIN;
                    control_start_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (filt_idle) begin
                    state_d        = ST_LOAD;
                    cmd_tready_d   = 1'b1;
                    word_cnt_d     = '0;
                    wr_addr_d      = '0;
                    err_overflow_d = 1'b0;
                end
            end

            ST_LOAD: begin
                cmd_tready_d = 1'b1;
                if (beat_accepted) begin
                    if (!mem_full) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[CODE_ADDR_WIDTH-1:0];
                        wr_data_d  = cmd_TDATA;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        // Excess words are swallowed so the stream still
                        // reaches TLAST; the address never wraps.
                        err_overflow_d = 1'b1;
                    end
                    if (cmd_TLAST) begin
                        state_d      = ST_COMMIT;
                        cmd_tready_d = 1'b0;
                        prog_len_d   = word_cnt_d;
                    end
                end
            end

            ST_COMMIT: begin
                state_d         = ST_RUN;
                control_start_d = 1'b1;
                load_done_d     = 1'b1;
            end

            default: begin
                state_d         = ST_IDLE;
                control_start_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
        if (rst) begin
            state_q         <= ST_IDLE;
            control_start_q <= 1'b0;
            cmd_tready_q    <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            word_cnt_q      <= '0;
            prog_len_q      <= '0;
            load_done_q     <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            control_start_q <= control_start_d;
            cmd_tready_q    <= cmd_tready_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            word_cnt_q      <= word_cnt_d;
            prog_len_q      <= prog_len_d;
            load_done_q     <= load_done_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    assign cmd_TREADY    = cmd_tready_q;
    assign control_start = control_start_q;
    assign inst_wr_en    = wr_en_q;
    assign inst_wr_addr  = wr_addr_q;
    assign inst_wr_data  = wr_data_q;
    assign prog_len      = prog_len_q;
    assign load_done     = load_done_q;
    assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_bpf_code_loader.sv
// Testbench for bpf_code_loader: directed programs, a behavioural model
// checked every cycle, and literal expectations for each scenario.
`timescale 1ns/1ps

module tb_bpf_code_loader;

    localparam int DEPTH = 512;
    localparam int DW    = 64;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cmd_tdata;
    logic          cmd_tvalid;
    logic          cmd_tlast;
    logic          cmd_tready;
    logic          filt_idle;
    logic          control_start;
    logic [AW-1:0] inst_wr_addr;
    logic [DW-1:0] inst_wr_data;
    logic          inst_wr_en;
    logic [AW:0]   prog_len;
    logic          load_done;
    logic          err_overflow;

    bpf_code_loader #(
        .INST_MEM_DEPTH (DEPTH),
        .CODE_DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_TDATA    (cmd_tdata),
        .cmd_TVALID   (cmd_tvalid),
        .cmd_TLAST    (cmd_tlast),
        .cmd_TREADY   (cmd_tready),
        .filt_idle    (filt_idle),
        .control_start(control_start),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .inst_wr_en   (inst_wr_en),
        .prog_len     (prog_len),
        .load_done    (load_done),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the loader must be doing, tracked as the
    // phases of a reload episode. Updated on each clock edge from the
    // inputs the bench is driving; holds the outputs expected for the
    // following cycle.
    // ------------------------------------------------------------------
    bit          m_running;   // filter enabled
    bit          m_waiting;   // stopped, waiting for idle cores
    bit          m_taking;    // accepting program words
    bit          m_closing;   // one wrap-up cycle after TLAST
    bit          m_done;
    bit          m_ovf;
    bit          m_wr;
    int          m_beats;
    int          m_len;
    int          m_addr;
    logic [63:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_running = 0; m_waiting = 0; m_taking = 0; m_closing = 0;
            m_done = 0; m_ovf = 0; m_wr = 0;
            m_beats = 0; m_len = 0; m_addr = 0; m_data = '0;
        end else begin
            m_wr   = 0;
            m_done = 0;
            if (m_closing) begin
                m_closing = 0;
                m_running = 1;
                m_done    = 1;
            end else if (m_taking) begin
                if (cmd_tvalid) begin
                    if (m_beats < DEPTH) begin
                        m_wr   = 1;
                        m_addr = m_beats;
                        m_data = cmd_tdata;
                        m_beats++;
                    end else begin
                        m_ovf = 1;
                    end
                    if (cmd_tlast) begin
                        m_taking  = 0;
                        m_closing = 1;
                        m_len     = m_beats;
                    end
                end
            end else if (m_waiting) begin
                if (filt_idle) begin
                    m_waiting = 0;
                    m_taking  = 1;
                    m_beats   = 0;
                    m_ovf     = 0;
                end
            end else if (cmd_tvalid) begin
                m_waiting = 1;
                m_running = 0;
            end
        end
    end

    // Observed writes, for the literal per-load expectations.
    int          log_addr[$];
    logic [63:0] log_data[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("control_start", 64'(control_start), 64'(m_running));
            check("cmd_TREADY",    64'(cmd_tready),    64'(m_taking));
            check("inst_wr_en",    64'(inst_wr_en),    64'(m_wr));
            if (m_wr) begin
                check("inst_wr_addr", 64'(inst_wr_addr), 64'(m_addr));
                check("inst_wr_data", inst_wr_data,      m_data);
            end
            check("load_done",     64'(load_done),     64'(m_done));
            check("err_overflow",  64'(err_overflow),  64'(m_ovf));
            check("prog_len",      64'(prog_len),      64'(m_len));
            if (inst_wr_en) begin
                log_addr.push_back(int'(inst_wr_addr));
                log_data.push_back(inst_wr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Present words in order; each advances only after a handshake.
    // A gap of gap_len idle cycles is inserted before word index gap_at.
    task automatic send_words(input logic [63:0] words[$], input bit with_last,
                              input int gap_at, input int gap_len);
        int i      = 0;
        int budget = 3000;
        cmd_tvalid = 1'b1;
        cmd_tdata  = words[0];
        cmd_tlast  = with_last && (words.size() == 1);
        while (i < words.size()) begin
            @(negedge clk);
            if (cmd_tready) begin
                tick();
                i++;
                if (i < words.size()) begin
                    if (i == gap_at) begin
                        cmd_tvalid = 1'b0;
                        cmd_tlast  = 1'b0;
                        repeat (gap_len) @(posedge clk);
                        #1;
                    end
                    cmd_tvalid = 1'b1;
                    cmd_tdata  = words[i];
                    cmd_tlast  = with_last && (i == words.size() - 1);
                end else begin
                    cmd_tvalid = 1'b0;
                    cmd_tlast  = 1'b0;
                end
            end else begin
                tick();
                budget--;
                if (budget == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL handshake_timeout: got %0d beats, expected %0d", i, words.size());
                    cmd_tvalid = 1'b0;
                    cmd_tlast  = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Wait (bounded) for the load_done pulse; returns at that cycle's negedge.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_load_done: got no pulse, expected one within 50 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w[$];
        int          n_addr0;

        rst        = 1'b1;
        cmd_tdata  = '0;
        cmd_tvalid = 1'b0;
        cmd_tlast  = 1'b0;
        filt_idle  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_control_start", 64'(control_start), 64'h0);
        check("rst_tready",        64'(cmd_tready),    64'h0);
        check("rst_wr_en",         64'(inst_wr_en),    64'h0);
        check("rst_prog_len",      64'(prog_len),      64'h0);
        check("rst_err_overflow",  64'(err_overflow),  64'h0);

        // 4-word program with idle cores.
        tick();
        clear_log();
        w.delete();
        for (int i = 1; i <= 4; i++) w.push_back(64'(i * 'h11));
        send_words(w, 1'b1, -1, 0);
        wait_done("p4");
        check("p4_prog_len",      64'(prog_len),       64'd4);
        check("p4_err_overflow",  64'(err_overflow),   64'h0);
        check("p4_control_start", 64'(control_start),  64'h1);
        check("p4_writes",        64'(log_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("p4_addr", 64'(log_addr[i]), 64'(i));
            check("p4_data", log_data[i],      64'(('h11) * (i + 1)));
        end
        @(negedge clk);
        check("p4_load_done_single", 64'(load_done), 64'h0);

        // New program while running; cores busy for 10 cycles.
        tick();
        clear_log();
        filt_idle  = 1'b0;
        cmd_tvalid = 1'b1;
        cmd_tdata  = 64'hA1;
        cmd_tlast  = 1'b0;
        @(negedge clk);
        check("p2_cs_before_drop", 64'(control_start), 64'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("p2_drain_cs",    64'(control_start), 64'h0);
            check("p2_drain_ready", 64'(cmd_tready),    64'h0);
            check("p2_drain_wr",    64'(inst_wr_en),    64'h0);
        end
        tick();
        filt_idle = 1'b1;
        w.delete();
        w.push_back(64'hA1);
        w.push_back(64'hA2);
        send_words(w, 1'b1, -1, 0);
        wait_done("p2");
        check("p2_prog_len", 64'(prog_len),        64'd2);
        check("p2_writes",   64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("p2_addr0", 64'(log_addr[0]), 64'd0);
            check("p2_addr1", 64'(log_addr[1]), 64'd1);
            check("p2_data1", log_data[1],      64'hA2);
        end

        // 6-word program with a 3-cycle TVALID gap between beats 2 and 3.
        tick();
        clear_log();
        w.delete();
        for (int i = 0; i < 6; i++) w.push_back(64'h60 + 64'(i));
        send_words(w, 1'b1, 2, 3);
        wait_done("p6");
        check("p6_prog_len", 64'(prog_len),        64'd6);
        check("p6_writes",   64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++)
            check("p6_addr", 64'(log_addr[i]), 64'(i));

        // 514 words into a 512-deep memory.
        tick();
        clear_log();
        w.delete();
        for (int i = 0; i < 514; i++) w.push_back(64'h4000_0000_0000_0000 + 64'(i));
        send_words(w, 1'b1, -1, 0);
        wait_done("p514");
        check("p514_prog_len",     64'(prog_len),        64'd512);
        check("p514_err_overflow", 64'(err_overflow),    64'h1);
        check("p514_writes",       64'(log_addr.size()), 64'd512);
        n_addr0 = 0;
        foreach (log_addr[i]) if (log_addr[i] == 0) n_addr0++;
        check("p514_addr0_writes", 64'(n_addr0), 64'd1);
        if (log_addr.size() == 512) begin
            check("p514_last_addr", 64'(log_addr[511]), 64'd511);
            check("p514_last_data", log_data[511],      64'h4000_0000_0000_01FF);
        end

        // Single-word program clears the overflow flag.
        tick();
        clear_log();
        w.delete();
        w.push_back(64'hBEEF);
        send_words(w, 1'b1, -1, 0);
        wait_done("p1");
        check("p1_prog_len",     64'(prog_len),        64'd1);
        check("p1_err_overflow", 64'(err_overflow),    64'h0);
        check("p1_writes",       64'(log_addr.size()), 64'd1);
        if (log_addr.size() == 1) begin
            check("p1_addr", 64'(log_addr[0]), 64'd0);
            check("p1_data", log_data[0],      64'hBEEF);
        end

        // Reset in the middle of a load after 3 beats.
        tick();
        clear_log();
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back(64'h71 + 64'(i));
        send_words(w, 1'b0, -1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_writes",       64'(log_addr.size()), 64'd3);
        check("abort_control_start",64'(control_start),   64'h0);
        check("abort_tready",       64'(cmd_tready),      64'h0);
        check("abort_wr_en",        64'(inst_wr_en),      64'h0);
        check("abort_wr_addr",      64'(inst_wr_addr),    64'h0);
        check("abort_wr_data",      inst_wr_data,         64'h0);
        check("abort_prog_len",     64'(prog_len),        64'h0);
        check("abort_load_done",    64'(load_done),       64'h0);
        check("abort_err_overflow", 64'(err_overflow),    64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_stay_stopped", 64'(control_start), 64'h0);
        end
        tick();
        w.delete();
        w.push_back(64'h81);
        w.push_back(64'h82);
        send_words(w, 1'b1, -1, 0);
        wait_done("reload");
        check("reload_prog_len",      64'(prog_len),      64'd2);
        check("reload_control_start", 64'(control_start), 64'h1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
